// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scan-code constants, direction encoding and framer state encoding.
// The direction encoding is also consumed by the downstream keypress FSM.
package ps2_pkg;

    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BRK      = 8'hF0;
    localparam logic [7:0] SC_PAUSE    = 8'hE1;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_OVR0     = 8'h00;
    localparam logic [7:0] SC_OVR1     = 8'hFF;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] SC_RESEND   = 8'hFE;

    localparam logic [7:0] SC_UP_ARROW = 8'h75;
    localparam logic [7:0] SC_DN_ARROW = 8'h72;
    localparam logic [7:0] SC_LT_ARROW = 8'h6B;
    localparam logic [7:0] SC_RT_ARROW = 8'h74;
    localparam logic [7:0] SC_W        = 8'h1D;
    localparam logic [7:0] SC_S        = 8'h1B;
    localparam logic [7:0] SC_A        = 8'h1C;
    localparam logic [7:0] SC_D        = 8'h23;

    // Pause is E1 followed by seven more bytes that carry no key meaning.
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_e;

    typedef struct packed {
        logic hit;
        dir_e dir;
    } dir_lookup_t;

    function automatic logic is_status(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_ECHO);
    endfunction

    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == SC_OVR0) || (b == SC_OVR1) || (b == SC_BAT_FAIL) || (b == SC_RESEND);
    endfunction

    // Arrow keys only match with the E0 prefix, WASD only without it.
    function automatic dir_lookup_t dir_lookup(input logic [7:0] code, input logic ext);
        dir_lookup_t r;
        r.hit = 1'b1;
        r.dir = DIR_UP;
        if (ext) begin
            case (code)
                SC_UP_ARROW: r.dir = DIR_UP;
                SC_DN_ARROW: r.dir = DIR_DOWN;
                SC_LT_ARROW: r.dir = DIR_LEFT;
                SC_RT_ARROW: r.dir = DIR_RIGHT;
                default:     r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:    r.dir = DIR_UP;
                SC_S:    r.dir = DIR_DOWN;
                SC_A:    r.dir = DIR_LEFT;
                SC_D:    r.dir = DIR_RIGHT;
                default: r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Idle counter bounding the gap between bytes of a multi-byte sequence.
// expired_o is high while the count sits at TIMEOUT_CYCLES-1.
module ps2_prefix_timer #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= cnt_q + W'(1);
    end

    assign expired_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ps2_scancode_framer.sv
// Frames PS/2 set-2 bytes into key events (E0/F0 stripped, Pause and status bytes
// dropped) and tracks held/newly-pressed state of the four direction keys.
module ps2_scancode_framer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       dir_valid,
    output logic [1:0] direction,
    output logic [3:0] dir_held,
    output logic       err
);
    state_e      state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic        evt_valid_q, evt_ext_q, evt_brk_q, dir_valid_q, err_q;
    logic [7:0]  evt_code_q;
    dir_e        direction_q, direction_d;
    logic [3:0]  held_q, held_d;
    logic        emit, emit_ext, emit_brk, dir_new, err_d;
    logic        tmo_clr, tmo_expired;
    dir_lookup_t lk;

    assign tmo_clr = rx_valid || (state_q == ST_IDLE);

    ps2_prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk_i     (CLOCK_50),
        .rst_i     (reset),
        .clr_i     (tmo_clr),
        .en_i      (state_q != ST_IDLE),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        err_d    = 1'b0;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_EXT)         state_d = ST_EXT;
                    else if (rx_data == SC_BRK)    state_d = ST_BRK;
                    else if (rx_data == SC_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_SKIP;
                    end
                    else if (is_err_byte(rx_data)) err_d = 1'b1;
                    else if (!is_status(rx_data))  emit  = 1'b1;
                end
                ST_EXT: begin
                    if (rx_data == SC_BRK) state_d = ST_EXT_BRK;
                    else if (rx_data != SC_EXT) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    // F0 E0 is malformed; treat it like E0 F0 rather than dropping the key.
                    if (rx_data == SC_EXT) state_d = ST_EXT_BRK;
                    else if (rx_data != SC_BRK) begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    emit     = 1'b1;
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((state_q != ST_IDLE) && tmo_expired) begin
            state_d = ST_IDLE;
            skip_d  = '0;
            err_d   = 1'b1;
        end

        lk          = dir_lookup(rx_data, emit_ext);
        held_d      = held_q;
        direction_d = direction_q;
        dir_new     = 1'b0;
        if (emit && lk.hit) begin
            if (emit_brk) begin
                held_d[lk.dir] = 1'b0;
            end else if (!held_q[lk.dir]) begin
                held_d[lk.dir] = 1'b1;
                direction_d    = lk.dir;
                dir_new        = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            skip_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
            evt_ext_q   <= 1'b0;
            evt_brk_q   <= 1'b0;
            dir_valid_q <= 1'b0;
            direction_q <= DIR_UP;
            held_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            evt_valid_q <= emit;
            dir_valid_q <= dir_new;
            direction_q <= direction_d;
            held_q      <= held_d;
            err_q       <= err_d;
            if (emit) begin
                evt_code_q <= rx_data;
                evt_ext_q  <= emit_ext;
                evt_brk_q  <= emit_brk;
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign evt_ext   = evt_ext_q;
    assign evt_break = evt_brk_q;
    assign dir_valid = dir_valid_q;
    assign direction = direction_q;
    assign dir_held  = held_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ps2_scancode_framer.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// key/prefix/pause/status traffic compared every cycle against a flag-based model.
module tb_ps2_scancode_framer;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       evt_valid, evt_ext, evt_break, dir_valid, err;
    logic [7:0] evt_code;
    logic [1:0] direction;
    logic [3:0] dir_held;

    ps2_scancode_framer #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .dir_valid (dir_valid),
        .direction (direction),
        .dir_held  (dir_held),
        .err       (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: collected-prefix flags, bytes left to skip, idle cycles in a sequence.
    bit         m_ext, m_brk;
    int         m_skip, m_idle;
    logic       e_evt, e_ext, e_brk, e_dirv, e_err;
    logic [7:0] e_code;
    logic [1:0] e_dir;
    logic [3:0] e_held;

    logic [7:0] arrow [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] wasd  [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};

    // Observations taken from the DUT for the directed literal checks.
    int         n_evt, n_dirv, n_err, n_brk;
    logic [7:0] last_code;
    logic       last_ext, last_brk;

    function automatic int dir_of(input logic [7:0] c, input bit ext);
        for (int i = 0; i < 4; i++)
            if ((ext ? arrow[i] : wasd[i]) == c) return i;
        return -1;
    endfunction

    task automatic model_event(input logic [7:0] c, input bit ext, input bit brk);
        int d;
        d = dir_of(c, ext);
        e_evt = 1'b1; e_code = c; e_ext = ext; e_brk = brk;
        m_ext = 0; m_brk = 0;
        if (d >= 0) begin
            if (brk) e_held[d] = 1'b0;
            else if (!e_held[d]) begin
                e_held[d] = 1'b1;
                e_dir     = d[1:0];
                e_dirv    = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        bit in_seq;
        logic [7:0] b;
        if (reset) begin
            m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
            e_evt = 0; e_ext = 0; e_brk = 0; e_dirv = 0; e_err = 0;
            e_code = 8'h00; e_dir = 2'b00; e_held = 4'b0000;
            return;
        end
        e_evt = 0; e_dirv = 0; e_err = 0;
        in_seq = m_ext || m_brk || (m_skip > 0);
        if (rx_valid) begin
            m_idle = 0;
            b = rx_data;
            if (m_skip > 0) m_skip--;
            else if (!m_ext && !m_brk) begin
                if (b == 8'hE0) m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else if (b == 8'hE1) m_skip = 7;
                else if (b inside {8'hAA, 8'hFA, 8'hEE}) ;
                else if (b inside {8'h00, 8'hFF, 8'hFC, 8'hFE}) e_err = 1;
                else model_event(b, 0, 0);
            end else if (m_ext && !m_brk) begin
                if (b == 8'hF0) m_brk = 1;
                else if (b != 8'hE0) model_event(b, 1, 0);
            end else if (!m_ext && m_brk) begin
                if (b == 8'hE0) m_ext = 1;
                else if (b != 8'hF0) model_event(b, 0, 1);
            end else model_event(b, 1, 1);
        end else if (!in_seq) m_idle = 0;
        else if (m_idle == T - 1) begin
            m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0; e_err = 1;
        end else m_idle++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, release strobe just after.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            tests++;
            if ({evt_valid, evt_code, evt_ext, evt_break, dir_valid, direction, dir_held, err} !==
                {e_evt, e_code, e_ext, e_brk, e_dirv, e_dir, e_held, e_err}) begin
                fails++;
                $display("FAIL cycle_cmp @%0t: got v=%b c=%h x=%b b=%b dv=%b d=%b h=%b e=%b, expected v=%b c=%h x=%b b=%b dv=%b d=%b h=%b e=%b",
                         $time, evt_valid, evt_code, evt_ext, evt_break, dir_valid, direction, dir_held, err,
                         e_evt, e_code, e_ext, e_brk, e_dirv, e_dir, e_held, e_err);
            end
            if (evt_valid) begin
                n_evt++; last_code = evt_code; last_ext = evt_ext; last_brk = evt_break;
                if (evt_break) n_brk++;
            end
            if (dir_valid) n_dirv++;
            if (err) n_err++;
        end
        @(posedge clk);
        model_step();
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clr_obs();
        n_evt = 0; n_dirv = 0; n_err = 0; n_brk = 0;
        last_code = 8'h00; last_ext = 1'b0; last_brk = 1'b0;
    endtask

    initial begin
        int r, d;
        logic [7:0] c;
        bit ext, brk;
        logic [7:0] st_bytes [7] = '{8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF, 8'hFC, 8'hFE};

        clr_obs();
        idle(2);
        reset = 1'b0;
        chk("reset_state", {evt_valid, evt_code, evt_ext, evt_break, dir_valid, direction, dir_held, err}, 32'h0);

        // W then right arrow, events 100 cycles apart
        clr_obs();
        send(8'h1D); idle(100);
        chk("w_code", last_code, 8'h1D);
        chk("w_ext_brk", {last_ext, last_brk}, 2'b00);
        chk("w_dirv", n_dirv, 1);
        chk("w_dir", direction, 2'b00);
        chk("w_held", dir_held, 4'b0001);
        send(8'hE0); send(8'h74); idle(3);
        chk("rt_code", last_code, 8'h74);
        chk("rt_ext", last_ext, 1'b1);
        chk("rt_dirv", n_dirv, 2);
        chk("rt_dir", direction, 2'b11);
        chk("rt_held", dir_held, 4'b1001);

        // Up arrow typematic repeat then release
        do_reset(); clr_obs();
        for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h75); idle(2); end
        send(8'hE0); send(8'hF0); send(8'h75); idle(3);
        chk("rep_dirv", n_dirv, 1);
        chk("rep_evts", n_evt, 4);
        chk("rep_brks", n_brk, 1);
        chk("rep_last", {last_code, last_ext, last_brk}, {8'h75, 2'b11});
        chk("rep_held", dir_held, 4'b0000);
        chk("rep_dir", direction, 2'b00);

        // Pause sequence back-to-back, then A
        do_reset(); clr_obs();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h1C); idle(3);
        chk("pause_evts", n_evt, 1);
        chk("pause_code", last_code, 8'h1C);
        chk("pause_dir", direction, 2'b10);
        chk("pause_held", dir_held, 4'b0100);

        // Timeout after E0, then a plain byte
        do_reset(); clr_obs();
        send(8'hE0); idle(T + 4);
        chk("tmo_err", n_err, 1);
        chk("tmo_evts", n_evt, 0);
        send(8'h72); idle(2);
        chk("tmo_next", {last_code, last_ext}, {8'h72, 1'b0});

        // Byte arriving exactly on the expiry cycle wins
        do_reset(); clr_obs();
        send(8'hE0); idle(T - 1); send(8'h74); idle(2);
        chk("edge_err", n_err, 0);
        chk("edge_evt", {last_code, last_ext}, {8'h74, 1'b1});

        // Status bytes ignored, FF flagged
        do_reset(); clr_obs();
        send(8'hAA); send(8'hFA); send(8'hFF); idle(3);
        chk("stat_evts", n_evt, 0);
        chk("stat_err", n_err, 1);

        // Reset discards a pending F0
        clr_obs();
        send(8'hF0); do_reset(); send(8'h1B); idle(2);
        chk("rst_brk", {last_code, last_brk}, {8'h1B, 1'b0});
        chk("rst_held", dir_held, 4'b0010);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3) do_reset();
            else if (r < 8) begin
                send(8'hE1);
                for (int i = 0; i < 7; i++) send(8'($urandom_range(0, 255)));
            end else if (r < 13) send(st_bytes[$urandom_range(0, 6)]);
            else if (r < 16) begin send(8'hE0); idle(T + $urandom_range(0, 3)); end
            else begin
                ext = 1'($urandom_range(0, 1));
                brk = 1'($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 1) == 1) begin
                    d = $urandom_range(0, 3);
                    c = ext ? arrow[d] : wasd[d];
                end else c = 8'($urandom_range(1, 8'hDF));
                if (ext) begin send(8'hE0); idle($urandom_range(0, 2)); end
                if (brk) begin send(8'hF0); idle($urandom_range(0, 2)); end
                send(c);
            end
            idle($urandom_range(0, 3));
        end
        idle(T + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
